// File: rtl/sdram_tester.sv
// sdram_tester: writes a seed-derived pattern over a block of SDRAM words through
// a four-phase request/response handshake, reads the block back, and counts
// the mismatches. Every output comes straight from a register.
module sdram_tester #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   osc_50,
  input  logic                   reset_50m_n,
  input  logic                   start,
  input  logic [24:0]            base_address,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic [31:0]            seed,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic [24:0]            first_error_address,
  output logic                   sdram_command,
  output logic                   sdram_write,
  output logic [24:0]            sdram_address,
  output logic [31:0]            sdram_data_write,
  input  logic                   sdram_response,
  input  logic [31:0]            sdram_data_read
);

  typedef enum logic [2:0] {IDLE, SYNC, WREQ, WREL, RREQ, RREL, FIN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [24:0]            r_base;
  logic [COUNT_WIDTH-1:0] r_count, r_index, r_err_cnt;
  logic [31:0]            r_seed;
  logic                   r_busy, r_done, r_cmd, r_wr;
  logic [24:0]            r_addr, r_first_err;
  logic [31:0]            r_wdata;

  logic                   w_accept, w_last, w_advance, w_issue, w_ack, w_mismatch;
  logic [COUNT_WIDTH-1:0] w_index_nxt;
  logic [24:0]            w_req_addr;
  logic [31:0]            w_exp;

  // Start is only honoured in IDLE; a zero-length run skips straight to FIN.
  assign w_accept    = (r_state == IDLE) && start && (word_count != '0);
  assign w_last      = (r_index == r_count - COUNT_WIDTH'(1));
  // Index moves on once the controller has released the previous response.
  assign w_advance   = ((r_state == WREL) || (r_state == RREL)) && !sdram_response;
  assign w_index_nxt = w_advance ? (w_last ? '0 : r_index + COUNT_WIDTH'(1)) : r_index;
  // Address wraps naturally at 2^25 through the 25-bit add.
  assign w_req_addr  = r_base + 25'(w_index_nxt);
  assign w_issue     = ((w_state_nxt == WREQ) && (r_state != WREQ)) ||
                       ((w_state_nxt == RREQ) && (r_state != RREQ));
  assign w_ack       = ((r_state == WREQ) || (r_state == RREQ)) && sdram_response;
  assign w_exp       = r_seed ^ {7'b0, r_addr};
  assign w_mismatch  = (r_state == RREQ) && sdram_response && (sdram_data_read != w_exp);

  // State register.
  always_ff @(posedge osc_50 or negedge reset_50m_n) begin
    if (!reset_50m_n) r_state <= IDLE;
    else              r_state <= w_state_nxt;
  end

  // Next-state logic; SYNC keeps new requests off the bus until a stale
  // response (e.g. one left over across a reset) has dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (word_count == '0) ? FIN : SYNC;
      SYNC:    if (!sdram_response) w_state_nxt = WREQ;
      WREQ:    if (sdram_response) w_state_nxt = WREL;
      WREL:    if (!sdram_response) w_state_nxt = w_last ? RREQ : WREQ;
      RREQ:    if (sdram_response) w_state_nxt = RREL;
      RREL:    if (!sdram_response) w_state_nxt = w_last ? FIN : RREQ;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered datapath: run parameters, request outputs, status and error tally.
  always_ff @(posedge osc_50 or negedge reset_50m_n) begin
    if (!reset_50m_n) begin
      r_base      <= '0;
      r_count     <= '0;
      r_seed      <= '0;
      r_index     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cmd       <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else begin
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (r_state == FIN);
      r_index <= w_index_nxt;
      if (w_accept) begin
        r_base      <= base_address;
        r_count     <= word_count;
        r_seed      <= seed;
        r_err_cnt   <= '0;
        r_first_err <= '0;
        r_index     <= '0;
      end
      if (w_issue) begin
        r_cmd   <= 1'b1;
        r_wr    <= (w_state_nxt == WREQ);
        r_addr  <= w_req_addr;
        r_wdata <= r_seed ^ {7'b0, w_req_addr};
      end else if (w_ack) begin
        r_cmd <= 1'b0;
      end
      if (w_mismatch) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + COUNT_WIDTH'(1);
        if (r_err_cnt == '0) r_first_err <= r_addr;
      end
    end
  end

  assign busy                = r_busy;
  assign done                = r_done;
  assign error_count         = r_err_cnt;
  assign first_error_address = r_first_err;
  assign sdram_command       = r_cmd;
  assign sdram_write         = r_wr;
  assign sdram_address       = r_addr;
  assign sdram_data_write    = r_wdata;

endmodule

// File: tb/tb_sdram_tester.sv
// tb_sdram_tester: random-latency SDRAM responder with a memory model, a
// transaction log, and a run-level reference model derived from the pattern rules.
module tb_sdram_tester;

  logic        osc_50 = 1'b0;
  logic        reset_50m_n;
  logic        start;
  logic [24:0] base_address;
  logic [15:0] word_count;
  logic [31:0] seed;
  logic        busy, done;
  logic [15:0] error_count;
  logic [24:0] first_error_address;
  logic        sdram_command, sdram_write;
  logic [24:0] sdram_address;
  logic [31:0] sdram_data_write;
  logic        sdram_response;
  logic [31:0] sdram_data_read;

  sdram_tester #(.COUNT_WIDTH(16)) dut (
    .osc_50(osc_50), .reset_50m_n(reset_50m_n), .start(start),
    .base_address(base_address), .word_count(word_count), .seed(seed),
    .busy(busy), .done(done), .error_count(error_count),
    .first_error_address(first_error_address),
    .sdram_command(sdram_command), .sdram_write(sdram_write),
    .sdram_address(sdram_address), .sdram_data_write(sdram_data_write),
    .sdram_response(sdram_response), .sdram_data_read(sdram_data_read)
  );

  always #5 osc_50 = ~osc_50;

  typedef struct packed { logic wr; logic [24:0] a; logic [31:0] d; } txn_t;

  txn_t        txq[$];
  logic [31:0] mem [logic [24:0]];
  bit          bad [logic [24:0]];
  bit          rsp_stick = 1'b0;
  int          n_cmp = 0, n_err = 0, viol = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responder: serves one request at a time with 0..20 cycles latency and
  // keeps the response up 1..5 cycles after the command drops (or longer
  // while rsp_stick holds a read response).
  txn_t r_t;
  int   r_guard;
  initial begin
    sdram_response  = 1'b0;
    sdram_data_read = '0;
    forever begin
      @(negedge osc_50);
      if (sdram_command && !sdram_response && reset_50m_n) begin
        r_t.wr = sdram_write;
        r_t.a  = sdram_address;
        r_t.d  = sdram_write ? sdram_data_write : 32'h0;
        repeat ($urandom_range(0, 20)) @(negedge osc_50);
        if (r_t.wr) mem[r_t.a] = r_t.d;
        else sdram_data_read = (mem.exists(r_t.a) ? mem[r_t.a] : 32'h0) ^
                               (bad.exists(r_t.a) ? ($urandom | 32'h1) : 32'h0);
        txq.push_back(r_t);
        sdram_response = 1'b1;
        r_guard = 0;
        while (sdram_command && r_guard < 200) begin @(negedge osc_50); r_guard++; end
        repeat ($urandom_range(1, 5)) @(negedge osc_50);
        while (rsp_stick && !r_t.wr) @(negedge osc_50);
        sdram_response = 1'b0;
      end
    end
  end

  // Protocol monitor: command must never rise into a live response, and the
  // request fields must not move while the command is up.
  logic        p_cmd = 1'b0;
  logic [57:0] p_req = '0;
  always @(posedge osc_50) begin
    #1;
    if (sdram_command && !p_cmd && sdram_response) viol++;
    if (sdram_command && p_cmd && ({sdram_write, sdram_address, sdram_data_write} != p_req)) viol++;
    p_cmd = sdram_command;
    p_req = {sdram_write, sdram_address, sdram_data_write};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_run(input logic [24:0] b, input int cnt, input logic [31:0] sd);
    @(negedge osc_50);
    txq.delete();
    base_address = b; word_count = 16'(cnt); seed = sd; start = 1'b1;
    @(negedge osc_50);
    // Scramble the inputs to show the DUT works from its captured copies.
    start = 1'b0; base_address = 25'($urandom); seed = $urandom; word_count = 16'($urandom);
  endtask

  task automatic finish_run(input string tag, input logic [24:0] b, input int cnt, input logic [31:0] sd);
    int          cyc, exp_err;
    logic [24:0] exp_first, a;
    logic [31:0] d;
    bit          wr;
    cyc = 0;
    while (done !== 1'b1 && cyc < 5000) begin @(negedge osc_50); cyc++; end
    chk({tag, "_done"}, 64'(done), 64'd1);
    exp_err = 0; exp_first = '0;
    chk({tag, "_ntxn"}, 64'(txq.size()), 64'(2 * cnt));
    for (int i = 0; i < 2 * cnt; i++) begin
      wr = (i < cnt);
      a  = 25'((longint'(b) + (i % cnt)) % 64'd33554432);
      d  = wr ? (sd ^ {7'b0, a}) : 32'h0;
      if (!wr && bad.exists(a)) begin
        exp_err++;
        if (exp_err == 1) exp_first = a;
      end
      if (i < txq.size()) chk($sformatf("%s_txn%0d", tag, i), 64'(txq[i]), 64'({wr, a, d}));
    end
    chk({tag, "_errcnt"}, 64'(error_count), 64'(exp_err));
    chk({tag, "_firsterr"}, 64'(first_error_address), 64'(exp_first));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge osc_50);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_protocol"}, 64'(viol), 64'd0);
  endtask

  task automatic run_check(input string tag, input logic [24:0] b, input int cnt, input logic [31:0] sd);
    start_run(b, cnt, sd);
    finish_run(tag, b, cnt, sd);
  endtask

  initial begin
    int          cyc, cmd_cycles, cnt;
    logic [24:0] b;
    logic [31:0] sd;
    reset_50m_n = 1'b0; start = 1'b0; base_address = '0; word_count = '0; seed = '0;
    repeat (3) @(negedge osc_50);
    chk("rst_outputs", {busy, done, error_count, first_error_address, sdram_command,
                        sdram_write, sdram_address}, 64'd0);
    chk("rst_wdata", 64'(sdram_data_write), 64'd0);
    reset_50m_n = 1'b1;
    @(negedge osc_50);
    chk("idle_busy", 64'(busy), 64'd0);

    // Ideal run at 0x100..0x103.
    bad.delete();
    run_check("basic", 25'h100, 4, 32'hA5A5A5A5);
    chk("basic_err_const", 64'(error_count), 64'd0);

    // Two corrupted reads.
    bad.delete(); bad[25'h102] = 1'b1; bad[25'h103] = 1'b1;
    run_check("corrupt", 25'h100, 4, 32'hA5A5A5A5);
    chk("corrupt_err_const", {error_count, first_error_address}, {16'd2, 25'h102});

    // Address wrap at the top of the space.
    bad.delete();
    run_check("wrap", 25'h1FFFFFE, 3, 32'h1234_5678);

    // Zero-length run: done two cycles after start, no commands.
    @(negedge osc_50);
    txq.delete();
    word_count = '0; start = 1'b1;
    @(negedge osc_50);
    start = 1'b0;
    chk("zero_cyc1", {busy, done}, 64'b10);
    @(negedge osc_50);
    chk("zero_done", {busy, done, sdram_command}, 64'b010);
    @(negedge osc_50);
    chk("zero_after", {busy, done}, 64'b00);
    chk("zero_ntxn", 64'(txq.size()), 64'd0);

    // Randomized runs with random corruption.
    for (int r = 0; r < 6; r++) begin
      b   = (r % 2 == 0) ? 25'($urandom) : (25'h1FFFFFF - 25'($urandom_range(0, 4)));
      cnt = $urandom_range(1, 7);
      sd  = $urandom;
      bad.delete();
      for (int k = 0; k < cnt; k++)
        if ($urandom_range(0, 2) == 0) bad[25'((longint'(b) + k) % 64'd33554432)] = 1'b1;
      run_check($sformatf("rand%0d", r), b, cnt, sd);
    end

    // Reset in the middle of a read while the controller holds its response.
    bad.delete();
    rsp_stick = 1'b1;
    start_run(25'h2000, 3, 32'hCAFE_F00D);
    cyc = 0;
    while (!(sdram_command && !sdram_write && sdram_response) && cyc < 5000) begin
      @(negedge osc_50); cyc++;
    end
    chk("rst_reach_rreq", 64'(cyc < 5000), 64'd1);
    reset_50m_n = 1'b0;
    #1;
    chk("rst_mid_cmd", {sdram_command, busy, error_count}, 64'd0);
    @(negedge osc_50);
    reset_50m_n = 1'b1;
    start_run(25'h40, 2, 32'h0F0F_0F0F);
    cmd_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge osc_50);
      if (sdram_command) cmd_cycles++;
    end
    chk("sync_blocked", {busy, sdram_response, 8'(cmd_cycles)}, {1'b1, 1'b1, 8'd0});
    rsp_stick = 1'b0;
    finish_run("after_rst", 25'h40, 2, 32'h0F0F_0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_tester.md
SDRAM_TESTER -- requirements
Module: sdram_tester

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16: width of the word-count input and the error counter.
REQ-002 SHALL have port osc_50, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_50m_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: when high in IDLE, begins a test run.
REQ-005 SHALL have port base_address, input, 25: first SDRAM word address; sampled on accepted start.
REQ-006 SHALL have port word_count, input, COUNT_WIDTH: number of words to test; sampled on accepted start.
REQ-007 SHALL have port seed, input, 32: pattern seed; sampled on accepted start.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at run completion.
REQ-010 SHALL have port error_count, output, COUNT_WIDTH: mismatches in current/last run.
REQ-011 SHALL have port first_error_address, output, 25: address of first mismatch in current/last run.
REQ-012 SHALL have port sdram_command, output, 1: request to the SDRAM controller (four-phase handshake).
REQ-013 SHALL have port sdram_write, output, 1: 1 = write, 0 = read; valid while sdram_command is high.
REQ-014 SHALL have port sdram_address, output, 25: word address; valid while sdram_command is high.
REQ-015 SHALL have port sdram_data_write, output, 32: write data; valid while sdram_command is high.
REQ-016 SHALL have port sdram_response, input, 1: completion from the controller.
REQ-017 SHALL have port sdram_data_read, input, 32: read data; valid while sdram_response is high after a read.

Function
REQ-018 SHALL drive all outputs from registers.
REQ-019 SHALL implement states IDLE, SYNC, WREQ, WREL, RREQ, RREL, FIN.
REQ-020 SHALL, in IDLE with start=1 and word_count!=0, capture inputs, clear error_count and first_error_address, set index=0, and go to SYNC.
REQ-021 SHALL, in IDLE with start=1 and word_count=0, go to FIN without issuing any command.
REQ-022 SHALL ignore start in every state except IDLE.
REQ-023 SHALL remain in SYNC until sdram_response=0, then go to WREQ.
REQ-024 SHALL hold sdram_command=1 throughout WREQ/RREQ; address, write and data stay stable until sdram_response is seen high.
REQ-025 SHALL set sdram_address = (base_address + index) mod 2^25 and sdram_data_write = seed XOR {7'b0, sdram_address}.
REQ-026 SHALL, on the edge sampling sdram_response=1 in WREQ, go to WREL with sdram_command=0 on the next cycle.
REQ-027 SHALL, in WREL, wait for sdram_response=0, then increment index; if index was word_count-1, reset index to 0 and go to RREQ, else go to WREQ.
REQ-028 SHALL, on the edge sampling sdram_response=1 in RREQ, compare sdram_data_read with the expected pattern for that address, then go to RREL.
REQ-029 SHALL, on mismatch, increment error_count, saturating at all-ones; if error_count was 0, load first_error_address with the current address.
REQ-030 SHALL, in RREL, wait for sdram_response=0, then advance as in REQ-027, going to FIN after the last word.
REQ-031 SHALL, in FIN, pulse done for one cycle and return to IDLE; error_count and first_error_address hold until the next accepted start.
REQ-032 SHALL never assert sdram_command while sdram_response=1 from the previous transaction.

Reset
REQ-033 SHALL, while reset_50m_n=0, force state=IDLE, sdram_command=0, sdram_write=0, sdram_address=0, sdram_data_write=0, busy=0, done=0, error_count=0, first_error_address=0, index=0.
REQ-034 SHALL, after reset mid-transaction, block new commands via SYNC until the controller drops sdram_response.

Verification
REQ-035 SHALL test: base=0x100, count=4, seed=0xA5A5A5A5, ideal responder -> 4 writes then 4 reads at 0x100..0x103, done pulse, error_count=0.
REQ-036 SHALL test: responder corrupts read of 0x102 and 0x103 -> error_count=2, first_error_address=0x102.
REQ-037 SHALL test: base=0x1FFFFFE, count=3 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000.
REQ-038 SHALL test: count=0 -> done pulses 2 cycles after start, sdram_command stays 0.
REQ-039 SHALL test: responder delays response 0..20 cycles and holds it 1..5 cycles after command drops -> no overlap, command never high with response high between transactions.
REQ-040 SHALL test: reset asserted during RREQ while response is held high -> sdram_command=0 immediately; the next run waits in SYNC until response=0.
